// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note event valid/ready stream from the MIDI decoder into the voice allocator
interface voice_allocator_if #(
  parameter int NOTE_WIDTH     = 7,
  parameter int VELOCITY_WIDTH = 7
);
  logic                      event_valid;
  logic                      event_ready;
  logic                      event_on;
  logic [NOTE_WIDTH-1:0]     event_note;
  logic [VELOCITY_WIDTH-1:0] event_velocity;

  modport master (
    output event_valid, event_on, event_note, event_velocity,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_on, event_note, event_velocity,
    output event_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - maps note events onto synthesis pipelines; VOICE_STEAL_EN steals the oldest voice when all are busy
module voice_allocator #(
  parameter int PIPELINE_COUNT = 4,
  parameter int NOTE_WIDTH     = 7,
  parameter int VELOCITY_WIDTH = 7,
  parameter int AGE_WIDTH      = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  voice_allocator_if.slave                              evt,
  output logic [PIPELINE_COUNT-1:0]                     voice_active,
  output logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0]     voice_note,
  output logic [PIPELINE_COUNT-1:0][VELOCITY_WIDTH-1:0] voice_velocity,
  output logic [PIPELINE_COUNT-1:0]                     voice_trigger,
  output logic [PIPELINE_COUNT-1:0]                     voice_release,
  output logic                                          event_dropped
);
  localparam int IDX_W = (PIPELINE_COUNT > 1) ? $clog2(PIPELINE_COUNT) : 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  typedef enum logic {IDLE, PROCESS} state_t;
  state_t state, state_next;

  logic                                          lat_on;
  logic [NOTE_WIDTH-1:0]                         lat_note;
  logic [VELOCITY_WIDTH-1:0]                     lat_velocity;
  logic [PIPELINE_COUNT-1:0][AGE_WIDTH-1:0]      age, age_next;
  logic [PIPELINE_COUNT-1:0]                     active_next, trigger_next, release_next;
  logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0]     note_next;
  logic [PIPELINE_COUNT-1:0][VELOCITY_WIDTH-1:0] velocity_next;
  logic                                          dropped_next;
  logic                                          accept;
  logic                                          hit_found, free_found, assign_en;
  logic [IDX_W-1:0]                              hit_idx, free_idx, old_idx, target;
  logic [AGE_WIDTH-1:0]                          old_age;

  assign evt.event_ready = (state == IDLE);
  assign accept          = evt.event_valid && evt.event_ready;

  // Strict '>' while scanning upward keeps the lowest index on age ties.
  always_comb begin : search
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = age[0];
    for (int v = 0; v < PIPELINE_COUNT; v++) begin
      if (!hit_found && voice_active[v] && (voice_note[v] == lat_note)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(v);
      end
      if (!free_found && !voice_active[v]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(v);
      end
      if (age[v] > old_age) begin
        old_age = age[v];
        old_idx = IDX_W'(v);
      end
    end
  end

  always_comb begin : decide
    state_next    = state;
    active_next   = voice_active;
    note_next     = voice_note;
    velocity_next = voice_velocity;
    age_next      = age;
    trigger_next  = '0;
    release_next  = '0;
    dropped_next  = 1'b0;
    assign_en     = 1'b0;
    target        = '0;
    case (state)
      IDLE: begin
        if (accept) state_next = PROCESS;
      end
      PROCESS: begin
        state_next = IDLE;
        if (lat_on && (lat_velocity != '0)) begin
          if (hit_found) begin
            assign_en = 1'b1;
            target    = hit_idx;
          end else if (free_found) begin
            assign_en = 1'b1;
            target    = free_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            assign_en = 1'b1;
            target    = old_idx;
`else
            dropped_next = 1'b1;
`endif
          end
        end else if (hit_found) begin
          // Velocity-0 note-on lands here too; note/velocity registers are left intact.
          active_next[hit_idx]  = 1'b0;
          release_next[hit_idx] = 1'b1;
        end
        if (assign_en) begin
          for (int v = 0; v < PIPELINE_COUNT; v++) begin
            if (IDX_W'(v) == target) begin
              active_next[v]   = 1'b1;
              note_next[v]     = lat_note;
              velocity_next[v] = lat_velocity;
              age_next[v]      = '0;
              trigger_next[v]  = 1'b1;
            end else if (voice_active[v] && (age[v] != AGE_MAX)) begin
              age_next[v] = age[v] + AGE_WIDTH'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lat_on         <= 1'b0;
      lat_note       <= '0;
      lat_velocity   <= '0;
      voice_active   <= '0;
      voice_note     <= '0;
      voice_velocity <= '0;
      age            <= '0;
      voice_trigger  <= '0;
      voice_release  <= '0;
      event_dropped  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_on       <= evt.event_on;
        lat_note     <= evt.event_note;
        lat_velocity <= evt.event_velocity;
      end
      voice_active   <= active_next;
      voice_note     <= note_next;
      voice_velocity <= velocity_next;
      age            <= age_next;
      voice_trigger  <= trigger_next;
      voice_release  <= release_next;
      event_dropped  <= dropped_next;
    end
  end
endmodule
